// File: rtl/clz_normalizer32.sv
// -----------------------------------------------------------------------------
// clz_normalizer32
//
// Multi-cycle leading-zero counter / normalizer. Given an operand D it finds
// the left-shift count S that moves the most significant set bit of D up to
// the top bit, and the normalized word Y = D << S. It is the inverse of the
// barrel shifter: feeding S (low bits) and D into the shifter with a left
// shift reproduces Y.
//
// The search is binary: the step index k starts at CNT_WIDTH-2 and each clock
// tests the top 2**k bits of the work register. If they are all zero the
// register is shifted left by 2**k and the count is bumped by 2**k. After the
// k=0 step the top bit is set unless the operand was zero.
//
// Handshake (valid/ready style):
//   An operation is accepted on a rising edge where START=1 and READY=1; D is
//   captured on that same edge. READY is high only while idle, so START and D
//   are ignored at any other time. DONE is a one-cycle pulse; Y, S and ZERO
//   are valid from that cycle and held until the next operation completes.
//   There is no back-pressure on the result side.
//
// Ports:
//   CLK        in   1           clock, rising edge
//   RST        in   1           synchronous reset, active-high
//   START      in   1           request, sampled only while READY=1
//   D          in   DATA_WIDTH  operand, captured on accept
//   READY      out  1           idle, a new operation may be accepted
//   DONE       out  1           one-cycle result-valid pulse (registered)
//   Y          out  DATA_WIDTH  normalized word, 0 when D was 0
//   S          out  CNT_WIDTH   leading-zero count, DATA_WIDTH only for D==0
//   ZERO       out  1           captured operand was zero
//   state_dbg  out  2           current FSM state (0 idle, 1 shift, 2 done)
// -----------------------------------------------------------------------------
module clz_normalizer32 #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [DATA_WIDTH-1:0] D,
    output logic                  READY,
    output logic                  DONE,
    output logic [DATA_WIDTH-1:0] Y,
    output logic [CNT_WIDTH-1:0]  S,
    output logic                  ZERO,
    output logic [1:0]            state_dbg
);

    // Number of search steps, and the width of the running count. The count
    // can reach at most 2**STEPS - 1 (all steps taken), so STEPS bits suffice.
    localparam int STEPS = CNT_WIDTH - 1;
    localparam int K_W   = (STEPS > 1) ? $clog2(STEPS) : 1;

    localparam logic [K_W-1:0]       K_INIT   = K_W'(STEPS - 1);
    localparam logic [K_W-1:0]       K_ONE    = K_W'(1);
    localparam logic [CNT_WIDTH-1:0] S_ZERO_D = CNT_WIDTH'(DATA_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                state;
    logic [K_W-1:0]        k;       // current step index, step size is 2**k
    logic [DATA_WIDTH-1:0] w;       // work register being shifted up
    logic [STEPS-1:0]      c;       // shift accumulated so far

    logic [DATA_WIDTH-1:0] y_q;
    logic [CNT_WIDTH-1:0]  s_q;
    logic                  zero_q;
    logic                  done_q;

    // One search step, evaluated combinationally from the current work reg.
    logic [DATA_WIDTH-1:0] step_n;     // 2**k as a shift amount
    logic [DATA_WIDTH-1:0] top_mask;   // ones in the top step_n bit positions
    logic                  top_clear;  // top step_n bits of w are all zero
    logic [DATA_WIDTH-1:0] w_step;
    logic [STEPS-1:0]      c_step;
    logic                  last_step;
    logic                  final_msb;

    always_comb begin
        step_n    = DATA_WIDTH'(1) << k;
        top_mask  = ~({DATA_WIDTH{1'b1}} >> step_n);
        top_clear = ((w & top_mask) == '0);
        w_step    = top_clear ? (w << step_n) : w;
        c_step    = top_clear ? (c + step_n[STEPS-1:0]) : c;
        last_step = (k == '0);
        // After the last step the top bit is set for any nonzero operand, so
        // a clear top bit is how a zero operand is recognised.
        final_msb = w_step[DATA_WIDTH-1];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= ST_IDLE;
            k      <= K_INIT;
            w      <= '0;
            c      <= '0;
            y_q    <= '0;
            s_q    <= '0;
            zero_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        w     <= D;
                        c     <= '0;
                        k     <= K_INIT;
                        state <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    w <= w_step;
                    c <= c_step;
                    if (last_step) begin
                        // Results are loaded on the same edge as the final
                        // step, so DONE and the outputs rise together.
                        k      <= K_INIT;
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                        y_q    <= w_step;
                        zero_q <= ~final_msb;
                        s_q    <= final_msb ? {1'b0, c_step} : S_ZERO_D;
                    end else begin
                        k <= k - K_ONE;
                    end
                end

                ST_DONE: begin
                    // START is not looked at here; READY is low in this state.
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign READY     = (state == ST_IDLE);
    assign DONE      = done_q;
    assign Y         = y_q;
    assign S         = s_q;
    assign ZERO      = zero_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_clz_normalizer32.sv
module tb_clz_normalizer32;

    // ---------------------------------------------------------------- clock/reset
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic [31:0] D = '0;
    logic        READY;
    logic        DONE;
    logic [31:0] Y;
    logic [5:0]  S;
    logic        ZERO;
    logic [1:0]  state_dbg;

    always #5 CLK = ~CLK;

    clz_normalizer32 dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .D         (D),
        .READY     (READY),
        .DONE      (DONE),
        .Y         (Y),
        .S         (S),
        .ZERO      (ZERO),
        .state_dbg (state_dbg)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- reference
    // Linear scan from the top bit: the first set bit gives the count.
    function automatic void ref_clz(input logic [31:0] d, output logic [5:0] s,
                                    output logic [31:0] y, output logic z);
        s = 6'd32;
        for (int i = 31; i >= 0; i--) begin
            if (d[i]) begin
                s = 6'(31 - i);
                break;
            end
        end
        z = (d == 32'd0);
        y = z ? 32'd0 : (d << s);
    endfunction

    // ---------------------------------------------------------------- monitor
    // A DONE pulse is legal only if an accept happened since the last pulse
    // and no reset intervened.
    logic pending = 1'b0;
    int   done_total = 0;

    always @(posedge CLK) begin
        if (RST) pending = 1'b0;
        else if (START && READY) pending = 1'b1;
    end

    always @(negedge CLK) begin
        if (DONE) begin
            done_total++;
            chk("done_has_accept", 32'(pending), 32'd1);
            pending = 1'b0;
        end
    end

    // ---------------------------------------------------------------- driver
    // Runs one operation. lat counts falling edges from the accept edge up to
    // the first one where DONE is seen (6 for a 5-step search).
    task automatic do_op(input logic [31:0] d, output logic [31:0] y,
                         output logic [5:0] s, output logic z, output int lat);
        int guard;
        @(negedge CLK);
        guard = 0;
        while (!READY && guard < 20) begin
            @(negedge CLK);
            guard++;
        end
        START = 1'b1;
        D     = d;
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0;
        D     = $urandom;          // operand must not matter once captured
        lat   = 1;
        while (!DONE && lat < 20) begin
            @(negedge CLK);
            lat++;
        end
        if (!DONE) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no DONE expected DONE, d=%h state=%0d", d, state_dbg);
        end
        y = Y;
        s = S;
        z = ZERO;
    endtask

    // ---------------------------------------------------------------- vectors
    typedef struct {
        logic [31:0] d;
        logic [31:0] y;
        logic [5:0]  s;
        logic        zero;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [31:0] y_a, y_r, d_r;
        logic [5:0]  s_a, s_r;
        logic        z_a, z_r;
        int          lat;
        logic [31:0] ys[2];
        logic [5:0]  ss[2];
        int          cs[2];
        int          seen;
        int          done_snap;

        vecs[0] = '{32'h0000_0001, 32'h8000_0000, 6'd31, 1'b0};
        vecs[1] = '{32'h8000_0000, 32'h8000_0000, 6'd0,  1'b0};
        vecs[2] = '{32'h0000_0000, 32'h0000_0000, 6'd32, 1'b1};
        vecs[3] = '{32'h0001_2345, 32'h91A2_8000, 6'd15, 1'b0};
        vecs[4] = '{32'h0000_00FF, 32'hFF00_0000, 6'd24, 1'b0};
        vecs[5] = '{32'h4000_0000, 32'h8000_0000, 6'd1,  1'b0};
        vecs[6] = '{32'h0000_0010, 32'h8000_0000, 6'd27, 1'b0};
        vecs[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd0,  1'b0};

        // reset
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        chk("reset_y",     Y,           32'd0);
        chk("reset_s",     32'(S),      32'd0);
        chk("reset_zero",  32'(ZERO),   32'd0);
        chk("reset_done",  32'(DONE),   32'd0);
        chk("reset_ready", 32'(READY),  32'd1);

        // directed table
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].d, y_a, s_a, z_a, lat);
            chk($sformatf("vec%0d_y", i),    y_a,         vecs[i].y);
            chk($sformatf("vec%0d_s", i),    32'(s_a),    32'(vecs[i].s));
            chk($sformatf("vec%0d_zero", i), 32'(z_a),    32'(vecs[i].zero));
            chk($sformatf("vec%0d_lat", i),  32'(lat),    32'd6);
            if (i == 3)
                chk("vec3_shifter", vecs[i].d << s_a[4:0], y_a);
        end

        // results held after DONE
        repeat (3) @(negedge CLK);
        chk("hold_y", Y,      32'hFFFF_FFFF);
        chk("hold_s", 32'(S), 32'd0);

        // START held high: two back-to-back ops, D changes while busy
        done_snap = done_total;
        @(negedge CLK);
        START = 1'b1;
        D     = 32'h0000_00FF;
        @(posedge CLK);
        @(negedge CLK);
        D    = 32'h4000_0000;
        seen = 0;
        for (int i = 1; i <= 40 && seen < 2; i++) begin
            if (i > 1) @(negedge CLK);
            if (DONE) begin
                ys[seen] = Y;
                ss[seen] = S;
                cs[seen] = i;
                seen++;
            end
        end
        START = 1'b0;
        chk("b2b_seen", 32'(seen), 32'd2);
        if (seen == 2) begin
            chk("b2b_a_s",  32'(ss[0]), 32'd24);
            chk("b2b_a_y",  ys[0],      32'hFF00_0000);
            chk("b2b_b_s",  32'(ss[1]), 32'd1);
            chk("b2b_b_y",  ys[1],      32'h8000_0000);
            chk("b2b_a_lat", 32'(cs[0]),        32'd6);
            chk("b2b_gap",  32'(cs[1] - cs[0]), 32'd7);
        end
        repeat (12) @(negedge CLK);
        chk("b2b_pulses", 32'(done_total - done_snap), 32'd2);

        // reset in the middle of an operation
        @(negedge CLK);
        START = 1'b1;
        D     = 32'h0000_0001;
        @(posedge CLK);                 // accept edge
        @(negedge CLK);
        START = 1'b0;
        chk("busy_ready", 32'(READY), 32'd0);
        chk("busy_hold_y", Y, 32'h8000_0000);
        @(posedge CLK);                 // second edge after accept
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);                 // third edge: reset
        @(negedge CLK);
        RST = 1'b0;
        chk("abort_y",     Y,          32'd0);
        chk("abort_s",     32'(S),     32'd0);
        chk("abort_zero",  32'(ZERO),  32'd0);
        chk("abort_done",  32'(DONE),  32'd0);
        chk("abort_ready", 32'(READY), 32'd1);
        done_snap = done_total;
        repeat (10) @(negedge CLK);
        chk("abort_no_done", 32'(done_total - done_snap), 32'd0);
        do_op(32'h0000_0010, y_a, s_a, z_a, lat);
        chk("after_abort_s", 32'(s_a), 32'd27);
        chk("after_abort_y", y_a,      32'h8000_0000);

        // randomized operands against the reference model
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 7))
                0:       d_r = 32'd0;
                1, 2:    d_r = 32'd1 << $urandom_range(0, 31);
                3, 4:    d_r = $urandom >> $urandom_range(0, 31);
                default: d_r = $urandom;
            endcase
            ref_clz(d_r, s_r, y_r, z_r);
            do_op(d_r, y_a, s_a, z_a, lat);
            chk("rand_s",    32'(s_a), 32'(s_r));
            chk("rand_y",    y_a,      y_r);
            chk("rand_zero", 32'(z_a), 32'(z_r));
            chk("rand_lat",  32'(lat), 32'd6);
            if ($urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 3)) @(negedge CLK);
        end

        repeat (4) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
